// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared pipeline widths, fetch FSM states and the IF/ID record
package rv_pipe_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {FILL = 1'b0, RUN = 1'b1} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory read bus between fetch and a 1-cycle synchronous imem
interface fetch_stage_if;
  import rv_pipe_pkg::*;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  modport master (output imem_addr, input imem_rdata);
  modport slave (input imem_addr, output imem_rdata);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, cleared by synchronous reset
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge clk)
    r_count <= reset ? '0 : (inc && !(&r_count)) ? r_count + 1'b1 : r_count;
  assign count = r_count;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem address generation and IF/ID pipeline register
module fetch_stage
  import rv_pipe_pkg::XLEN, rv_pipe_pkg::fetch_state_t, rv_pipe_pkg::if_id_t,
         rv_pipe_pkg::FILL, rv_pipe_pkg::RUN;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              stall_IF_ID,
  input  logic              flush_IF_ID,
  input  logic              BRANCHTAKEN_EX,
  input  logic [XLEN-1:0]   BRANCHTARGET_EX,
  fetch_stage_if.master     imem,
  output logic [XLEN-1:0]   PC_ID,
  output logic [XLEN-1:0]   PC4_ID,
  output logic [XLEN-1:0]   INSTR_ID,
  output logic              VALID_ID,
  output logic              misalign_fault,
  output logic [XLEN-1:0]   stall_cnt,
  output logic [XLEN-1:0]   flush_cnt
);
  fetch_state_t    r_state, w_next_state;
  logic [XLEN-1:0] r_pc, w_addr;
  if_id_t          r_ifid;
  logic            r_misalign;
  // r_pc is the address whose data is on imem_rdata now; FILL re-issues it
  always_comb begin
    w_addr       = reset ? RESET_PC
                 : BRANCHTAKEN_EX ? {BRANCHTARGET_EX[XLEN-1:2], 2'b00}
                 : (!PCWrite || r_state == FILL) ? r_pc
                 : r_pc + 32'd4;
    w_next_state = reset ? FILL : RUN;
  end
  always_ff @(posedge clk) begin
    r_pc    <= w_addr;
    r_state <= w_next_state;
  end
  always_ff @(posedge clk)
    r_misalign <= reset ? 1'b0 : r_misalign | (BRANCHTAKEN_EX && BRANCHTARGET_EX[1:0] != 2'b00);
  always_ff @(posedge clk) begin
    if (reset || flush_IF_ID)
      r_ifid <= '{pc: reset ? RESET_PC : r_pc, pc4: (reset ? RESET_PC : r_pc) + 32'd4,
                  instr: NOP_INSTR, valid: 1'b0};
    else if (!stall_IF_ID)
      r_ifid <= '{pc: r_pc, pc4: r_pc + 32'd4,
                  instr: (r_state == RUN) ? imem.imem_rdata : NOP_INSTR,
                  valid: r_state == RUN};
  end
  sat_counter #(.WIDTH(XLEN)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall_IF_ID), .count(stall_cnt)
  );
  sat_counter #(.WIDTH(XLEN)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush_IF_ID), .count(flush_cnt)
  );
  assign imem.imem_addr = w_addr;
  assign PC_ID          = r_ifid.pc;
  assign PC4_ID         = r_ifid.pc4;
  assign INSTR_ID       = r_ifid.instr;
  assign VALID_ID       = r_ifid.valid;
  assign misalign_fault = r_misalign;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage against a 1-cycle imem returning addr^A5A5_0000
module tb_fetch_stage;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        v;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCWrite = 1'b1;
  logic        stall_IF_ID = 1'b0;
  logic        flush_IF_ID = 1'b0;
  logic        BRANCHTAKEN_EX = 1'b0;
  logic [31:0] BRANCHTARGET_EX = '0;
  logic [31:0] PC_ID, PC4_ID, INSTR_ID, stall_cnt, flush_cnt;
  logic        VALID_ID, misalign_fault;
  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        q[$];
  fetch_stage_if imem ();
  fetch_stage dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .stall_IF_ID(stall_IF_ID),
    .flush_IF_ID(flush_IF_ID), .BRANCHTAKEN_EX(BRANCHTAKEN_EX),
    .BRANCHTARGET_EX(BRANCHTARGET_EX), .imem(imem.master), .PC_ID(PC_ID),
    .PC4_ID(PC4_ID), .INSTR_ID(INSTR_ID), .VALID_ID(VALID_ID),
    .misalign_fault(misalign_fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) imem.imem_rdata <= imem.imem_addr ^ K;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rs, input logic pcw, input logic st, input logic fl,
                      input logic bt, input logic [31:0] tgt, input logic [31:0] exp_addr,
                      input logic [31:0] exp_pc, input logic exp_v);
    exp_t e;
    q.push_back('{pc: exp_pc, pc4: exp_pc + 32'd4, instr: exp_v ? exp_pc ^ K : NOP, v: exp_v});
    reset = rs; PCWrite = pcw; stall_IF_ID = st; flush_IF_ID = fl;
    BRANCHTAKEN_EX = bt; BRANCHTARGET_EX = tgt;
    @(negedge clk);
    check("imem_addr", imem.imem_addr, exp_addr);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("PC_ID", PC_ID, e.pc);
    check("PC4_ID", PC4_ID, e.pc4);
    check("INSTR_ID", INSTR_ID, e.instr);
    check("VALID_ID", {31'd0, VALID_ID}, {31'd0, e.v});
  endtask
  task automatic run(input logic [31:0] exp_addr, input logic [31:0] exp_pc);
    step(0, 1, 0, 0, 0, 0, exp_addr, exp_pc, 1);
  endtask
  initial begin
    @(posedge clk);
    #1;
    step(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    check("misalign_rst", {31'd0, misalign_fault}, 32'd0);
    check("stall_cnt_rst", stall_cnt, 32'd0);
    check("flush_cnt_rst", flush_cnt, 32'd0);
    step(0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    run(32'h4, 32'h0);
    run(32'h8, 32'h4);
    run(32'hC, 32'h8);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 32'hC, 32'h8, 1);
    check("stall_cnt_3", stall_cnt, 32'd3);
    run(32'h10, 32'hC);
    run(32'h14, 32'h10);
    step(0, 1, 0, 1, 1, 32'h100, 32'h100, 32'h14, 0);
    check("flush_cnt_1", flush_cnt, 32'd1);
    run(32'h104, 32'h100);
    run(32'h108, 32'h104);
    step(0, 0, 1, 1, 1, 32'h200, 32'h200, 32'h108, 0);
    check("stall_cnt_4", stall_cnt, 32'd4);
    check("flush_cnt_2", flush_cnt, 32'd2);
    run(32'h204, 32'h200);
    check("misalign_clear", {31'd0, misalign_fault}, 32'd0);
    step(0, 1, 0, 1, 1, 32'h102, 32'h100, 32'h204, 0);
    check("misalign_set", {31'd0, misalign_fault}, 32'd1);
    run(32'h104, 32'h100);
    run(32'h108, 32'h104);
    check("misalign_sticky", {31'd0, misalign_fault}, 32'd1);
    step(0, 1, 0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h108, 0);
    run(32'h0, 32'hFFFF_FFFC);
    run(32'h4, 32'h0);
    step(1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
    check("misalign_rst2", {31'd0, misalign_fault}, 32'd0);
    check("stall_cnt_rst2", stall_cnt, 32'd0);
    check("flush_cnt_rst2", flush_cnt, 32'd0);
    step(0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    run(32'h4, 32'h0);
    run(32'h8, 32'h4);
    run(32'hC, 32'h8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
